rs_cdb_writeback: RTL and testbench
===================================

# rs_cdb_writeback

Writeback arbiter and result queue feeding the RS-side port of the CDB. Collects results from two ALUs that can finish in the same cycle, buffers them in a small in-order FIFO, and broadcasts at most one result per cycle on RSCDB_*. The CDB fans these out to the LSB, RoB and Dispatcher. Drives a registered full signal back to the RS issue logic and drops all pending results on a RoB clear.

## Interface
- ADDR_WIDTH, 32, PC width
- RoB_WIDTH, 8, RoB index width
- WBQ_WIDTH, 3, log2 of queue depth
- WBQ_SIZE, 1 << WBQ_WIDTH, queue entries
---
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-high reset
- rdy_in  in  1  global ready; low freezes all state including outputs
- RoB_clear  in  1  misprediction flush from RoB
- ALU0_en  in  1  ALU0 result valid this cycle
- ALU0_RoB_index  in  RoB_WIDTH  destination RoB entry
- ALU0_value  in  32  result value
- ALU0_next_pc  in  ADDR_WIDTH  resolved next PC
- ALU1_en, ALU1_RoB_index, ALU1_value, ALU1_next_pc  in  1/RoB_WIDTH/32/ADDR_WIDTH  same for ALU1
- RSCDB_en  out  1  broadcast valid, registered
- RSCDB_RoB_index  out  RoB_WIDTH  registered
- RSCDB_value  out  32  registered
- RSCDB_next_pc  out  ADDR_WIDTH  registered
- WBQ_full  out  1  registered; RS must not issue to either ALU while high
- WBQ_overflow  out  1  sticky error flag; push arrived with no free slot

## Operation
- Entry = {RoB_index, value, next_pc}. Circular buffer, head/tail pointers WBQ_WIDTH bits wrapping modulo WBQ_SIZE, count WBQ_WIDTH+1 bits.
- Per active cycle (rdy_in=1, RoB_clear=0):
  - Pop: if count>0, head entry loads the output registers, RSCDB_en<=1, head advances.
  - Bypass: if count==0, ALU0 result (else ALU1 if only ALU1) loads the output registers directly. Any second same-cycle result is pushed.
  - No source: RSCDB_en<=0. The other output registers hold their last value.
  - Push order: ALU0 before ALU1 when both push. FIFO order is strict. There is no reordering by RoB index.
  - count_next = count + pushes − pops. Pushes and a pop in the same cycle are legal at any count.
  - A push with no free slot after that cycle's pop is dropped. It sets WBQ_overflow, which stays set until reset. Accepted entries are unaffected.
- WBQ_full <= (count_next >= WBQ_SIZE − 2). This covers two results already in flight from issue to ALU completion.
- RoB_clear=1 (takes priority over everything while rdy_in=1):
  - head=tail=0, count=0, RSCDB_en<=0, WBQ_full<=0.
  - Same-cycle ALU results are discarded.
  - WBQ_overflow is unchanged.
- rdy_in=0: no push, no pop, no clear. All registers hold, so an asserted RSCDB_en stays asserted. Consumers are frozen by the same rdy_in, so this produces no duplicate broadcast.
- Reset values: RSCDB_en=0, RSCDB_RoB_index=0, RSCDB_value=0, RSCDB_next_pc=0, WBQ_full=0, WBQ_overflow=0, count=0, head=tail=0.

## Timing
- Latency, empty queue: ALU result at edge N → RSCDB_* valid from edge N+1 for one cycle.
- Latency, queued entry: appears k+1 cycles after its push, where k = entries ahead of it.
- Throughput: one broadcast per active cycle while count>0 or bypass is possible.
- WBQ_full reflects count after edge N from edge N+1. RS samples it combinationally for issue at N+1.
- RoB_clear at edge N: RSCDB_en=0 from N+1. The first post-clear result can be pushed in cycle N+1.

## Structure
- Shared package `cdb_pkg`:
  - wb_entry_t = {RoB_index, value, next_pc}
  - RoB_WIDTH, ADDR_WIDTH
  - WBQ_WIDTH default
- Sub-module `wbq_fifo`: two-write/one-read circular buffer with count. It receives push0/push1/pop/clear and returns head entry and count.
- The top contains:
  - bypass mux
  - output registers
  - full and overflow logic

## Test plan
- Single ALU0 result {idx 5, 0x1234, pc 0x100} on empty queue → RSCDB_en=1 next cycle with those values, 0 the cycle after.
- ALU0 {1} and ALU1 {2} same cycle, then idle → broadcasts idx 1 then idx 2 on consecutive cycles; count returns to 0.
- Dual pushes every cycle from reset:
  - WBQ_full=1 first in the cycle after count reaches 6 (depth 8).
  - Entries drain in exact push order with no gap.
- Force pushes with count=8 while ignoring WBQ_full → dropped entry never broadcast; WBQ_overflow=1 and stays 1 after drain.
- Fill to 5 entries, assert RoB_clear together with ALU0_en → next cycle RSCDB_en=0, WBQ_full=0; no stale entry ever appears; a later push is broadcast normally.
- rdy_in low for 3 cycles while RSCDB_en=1 with 3 queued entries → outputs and count frozen; on resume the remaining entries drain in order. Async rst_in mid-drain → all outputs 0 immediately.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and sizing for the RS-side CDB writeback path.
package cdb_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int RoB_WIDTH  = 8;
    localparam int WBQ_WIDTH  = 3;
    localparam int WBQ_SIZE   = 1 << WBQ_WIDTH;

    // One ALU result as it travels through the queue and onto the CDB.
    typedef struct packed {
        logic [RoB_WIDTH-1:0]  rob_index;
        logic [31:0]           value;
        logic [ADDR_WIDTH-1:0] next_pc;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// Two-write / one-read circular buffer holding pending writeback results.
// push0 is always stored ahead of push1; the caller guarantees free space.
module wbq_fifo
    import cdb_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clear_i,
    input  logic                 push0_i,
    input  wb_entry_t            data0_i,
    input  logic                 push1_i,
    input  wb_entry_t            data1_i,
    input  logic                 pop_i,
    output wb_entry_t            head_o,
    output logic [WBQ_WIDTH:0]   count_o
);

    wb_entry_t            mem_q [WBQ_SIZE];
    logic [WBQ_WIDTH-1:0] head_q, head_d;
    logic [WBQ_WIDTH-1:0] tail_q, tail_d;
    logic [WBQ_WIDTH-1:0] wr1_idx;
    logic [WBQ_WIDTH:0]   count_q, count_d;
    logic                 act;

    // Pointer and occupancy update; clear wins over any same-cycle traffic.
    always_comb begin
        act     = en_i && !clear_i;
        wr1_idx = push0_i ? tail_q + {{(WBQ_WIDTH-1){1'b0}}, 1'b1} : tail_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (en_i && clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (act) begin
            head_d  = head_q + {{(WBQ_WIDTH-1){1'b0}}, pop_i};
            tail_d  = tail_q + {{(WBQ_WIDTH-1){1'b0}}, push0_i}
                             + {{(WBQ_WIDTH-1){1'b0}}, push1_i};
            count_d = count_q + {{WBQ_WIDTH{1'b0}}, push0_i}
                              + {{WBQ_WIDTH{1'b0}}, push1_i}
                              - {{WBQ_WIDTH{1'b0}}, pop_i};
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (act) begin
            if (push0_i) mem_q[tail_q]  <= data0_i;
            if (push1_i) mem_q[wr1_idx] <= data1_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/rs_cdb_writeback.sv
// Writeback arbiter for the RS-side CDB port: bypasses a result straight to
// the broadcast registers when the queue is empty, otherwise queues results
// in arrival order (ALU0 before ALU1) and broadcasts one per cycle.
module rs_cdb_writeback
    import cdb_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  RoB_clear,
    input  logic                  ALU0_en,
    input  logic [RoB_WIDTH-1:0]  ALU0_RoB_index,
    input  logic [31:0]           ALU0_value,
    input  logic [ADDR_WIDTH-1:0] ALU0_next_pc,
    input  logic                  ALU1_en,
    input  logic [RoB_WIDTH-1:0]  ALU1_RoB_index,
    input  logic [31:0]           ALU1_value,
    input  logic [ADDR_WIDTH-1:0] ALU1_next_pc,
    output logic                  RSCDB_en,
    output logic [RoB_WIDTH-1:0]  RSCDB_RoB_index,
    output logic [31:0]           RSCDB_value,
    output logic [ADDR_WIDTH-1:0] RSCDB_next_pc,
    output logic                  WBQ_full,
    output logic                  WBQ_overflow
);

    localparam logic [WBQ_WIDTH:0] SIZE_C   = (WBQ_WIDTH+1)'(WBQ_SIZE);
    localparam logic [WBQ_WIDTH:0] FULL_THR = (WBQ_WIDTH+1)'(WBQ_SIZE - 2);

    wb_entry_t          alu0_e, alu1_e, head_e, src_e;
    wb_entry_t          out_q, out_d;
    logic               en_q, en_d, full_q, full_d, ovf_q, ovf_d;
    logic [WBQ_WIDTH:0] count, count_next, free_slots;
    logic               pop, bypass0, bypass1, want0, want1, acc0, acc1;
    logic               drop, src_vld;

    assign alu0_e = '{rob_index: ALU0_RoB_index, value: ALU0_value, next_pc: ALU0_next_pc};
    assign alu1_e = '{rob_index: ALU1_RoB_index, value: ALU1_value, next_pc: ALU1_next_pc};

    // Source selection, push acceptance and next occupancy. Free space is
    // counted after this cycle's pop so a full queue can still accept one.
    always_comb begin
        pop        = (count != '0);
        bypass0    = !pop && ALU0_en;
        bypass1    = !pop && !ALU0_en && ALU1_en;
        want0      = ALU0_en && !bypass0;
        want1      = ALU1_en && !bypass1;
        free_slots = SIZE_C - count + {{WBQ_WIDTH{1'b0}}, pop};
        acc0       = want0 && (free_slots != '0);
        acc1       = want1 && (free_slots > {{WBQ_WIDTH{1'b0}}, acc0});
        drop       = (want0 && !acc0) || (want1 && !acc1);
        count_next = count + {{WBQ_WIDTH{1'b0}}, acc0}
                           + {{WBQ_WIDTH{1'b0}}, acc1}
                           - {{WBQ_WIDTH{1'b0}}, pop};
        src_vld    = pop || bypass0 || bypass1;
        src_e      = pop ? head_e : (bypass0 ? alu0_e : alu1_e);
    end

    wbq_fifo u_wbq (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .en_i    (rdy_in),
        .clear_i (RoB_clear),
        .push0_i (acc0),
        .data0_i (alu0_e),
        .push1_i (acc1),
        .data1_i (alu1_e),
        .pop_i   (pop),
        .head_o  (head_e),
        .count_o (count)
    );

    // Next values for broadcast, full and overflow; everything holds while rdy_in is low.
    always_comb begin
        en_d   = en_q;
        out_d  = out_q;
        full_d = full_q;
        ovf_d  = ovf_q;
        if (rdy_in) begin
            if (RoB_clear) begin
                en_d   = 1'b0;
                full_d = 1'b0;
            end else begin
                en_d = src_vld;
                if (src_vld) out_d = src_e;
                full_d = (count_next >= FULL_THR);
                if (drop) ovf_d = 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            en_q   <= 1'b0;
            out_q  <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            out_q  <= out_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
        end
    end

    assign RSCDB_en        = en_q;
    assign RSCDB_RoB_index = out_q.rob_index;
    assign RSCDB_value     = out_q.value;
    assign RSCDB_next_pc   = out_q.next_pc;
    assign WBQ_full        = full_q;
    assign WBQ_overflow    = ovf_q;

endmodule

// File: tb/tb_rs_cdb_writeback.sv
// Self-checking bench for rs_cdb_writeback against a queue-level reference model.
module tb_rs_cdb_writeback;
    import cdb_pkg::*;

    logic      clk_in = 1'b0;
    logic      rst_in, rdy_in, RoB_clear, ALU0_en, ALU1_en;
    wb_entry_t a0_e, a1_e;
    logic                  RSCDB_en, WBQ_full, WBQ_overflow;
    logic [RoB_WIDTH-1:0]  RSCDB_RoB_index;
    logic [31:0]           RSCDB_value;
    logic [ADDR_WIDTH-1:0] RSCDB_next_pc;

    int tests = 0;
    int fails = 0;

    wb_entry_t mq[$];
    wb_entry_t m_out;
    logic      m_en, m_full, m_ovf;

    always #5 clk_in = ~clk_in;

    rs_cdb_writeback dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .RoB_clear       (RoB_clear),
        .ALU0_en         (ALU0_en),
        .ALU0_RoB_index  (a0_e.rob_index),
        .ALU0_value      (a0_e.value),
        .ALU0_next_pc    (a0_e.next_pc),
        .ALU1_en         (ALU1_en),
        .ALU1_RoB_index  (a1_e.rob_index),
        .ALU1_value      (a1_e.value),
        .ALU1_next_pc    (a1_e.next_pc),
        .RSCDB_en        (RSCDB_en),
        .RSCDB_RoB_index (RSCDB_RoB_index),
        .RSCDB_value     (RSCDB_value),
        .RSCDB_next_pc   (RSCDB_next_pc),
        .WBQ_full        (WBQ_full),
        .WBQ_overflow    (WBQ_overflow)
    );

    function automatic wb_entry_t rnd_entry();
        wb_entry_t e;
        e.rob_index = RoB_WIDTH'($urandom);
        e.value     = $urandom;
        e.next_pc   = ADDR_WIDTH'($urandom);
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_out  = '0;
        m_en   = 1'b0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // One clock edge of the reference: broadcast the oldest item (queued first,
    // then this cycle's results in ALU0/ALU1 order), store the rest if room.
    task automatic model_step();
        wb_entry_t res[$];
        if (!rdy_in) return;
        if (RoB_clear) begin
            mq.delete();
            m_en   = 1'b0;
            m_full = 1'b0;
            return;
        end
        if (ALU0_en) res.push_back(a0_e);
        if (ALU1_en) res.push_back(a1_e);
        if (mq.size() > 0) begin
            m_out = mq.pop_front();
            m_en  = 1'b1;
        end else if (res.size() > 0) begin
            m_out = res.pop_front();
            m_en  = 1'b1;
        end else begin
            m_en = 1'b0;
        end
        while (res.size() > 0) begin
            if (mq.size() < WBQ_SIZE) mq.push_back(res.pop_front());
            else begin
                void'(res.pop_front());
                m_ovf = 1'b1;
            end
        end
        m_full = (mq.size() >= WBQ_SIZE - 2);
    endtask

    task automatic check(input string tag);
        tests++;
        assert (RSCDB_en === m_en) else begin
            fails++;
            $error("FAIL %s en: got %0b want %0b", tag, RSCDB_en, m_en);
        end
        tests++;
        assert (RSCDB_RoB_index === m_out.rob_index) else begin
            fails++;
            $error("FAIL %s idx: got %0h want %0h", tag, RSCDB_RoB_index, m_out.rob_index);
        end
        tests++;
        assert (RSCDB_value === m_out.value) else begin
            fails++;
            $error("FAIL %s value: got %0h want %0h", tag, RSCDB_value, m_out.value);
        end
        tests++;
        assert (RSCDB_next_pc === m_out.next_pc) else begin
            fails++;
            $error("FAIL %s pc: got %0h want %0h", tag, RSCDB_next_pc, m_out.next_pc);
        end
        tests++;
        assert (WBQ_full === m_full) else begin
            fails++;
            $error("FAIL %s full: got %0b want %0b", tag, WBQ_full, m_full);
        end
        tests++;
        assert (WBQ_overflow === m_ovf) else begin
            fails++;
            $error("FAIL %s overflow: got %0b want %0b", tag, WBQ_overflow, m_ovf);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_in);
        model_step();
        #1;
        check(tag);
    endtask

    task automatic set_in(input logic e0, input logic e1, input logic clr, input logic rdy);
        ALU0_en   = e0;
        ALU1_en   = e1;
        RoB_clear = clr;
        rdy_in    = rdy;
        a0_e      = rnd_entry();
        a1_e      = rnd_entry();
    endtask

    task automatic async_reset(input string tag);
        #2 rst_in = 1'b1;
        model_reset();
        #1 check(tag);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        model_reset();
        #1 check("reset");
        @(negedge clk_in);
        rst_in = 1'b0;

        // single bypassed result
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        a0_e = '{rob_index: 8'd5, value: 32'h1234, next_pc: 32'h100};
        step("single");
        tests++;
        assert (RSCDB_en === 1'b1 && RSCDB_RoB_index === 8'd5 && RSCDB_value === 32'h1234
                && RSCDB_next_pc === 32'h100) else begin
            fails++;
            $error("FAIL single_direct: got en=%0b idx=%0h want en=1 idx=5", RSCDB_en, RSCDB_RoB_index);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        step("single_idle");

        // two results in the same cycle
        set_in(1'b1, 1'b1, 1'b0, 1'b1);
        a0_e.rob_index = 8'd1;
        a1_e.rob_index = 8'd2;
        step("dual0");
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        step("dual1");
        tests++;
        assert (RSCDB_en === 1'b1 && RSCDB_RoB_index === 8'd2) else begin
            fails++;
            $error("FAIL dual_second: got en=%0b idx=%0h want en=1 idx=2", RSCDB_en, RSCDB_RoB_index);
        end
        step("dual2");
        step("dual3");

        // back-to-back dual pushes into overflow, then drain
        for (int i = 0; i < 11; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b1);
            step("fill");
        end
        for (int i = 0; i < 10; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1);
            step("drain");
        end
        tests++;
        assert (WBQ_overflow === 1'b1) else begin
            fails++;
            $error("FAIL ovf_sticky: got %0b want 1", WBQ_overflow);
        end

        // clear with five queued and a same-cycle ALU0 result
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b1);
            step("pre_clear");
        end
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        step("clear");
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1);
            step("post_clear");
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        step("after_clear");
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        step("after_clear_idle");

        // freeze with rdy_in low while broadcasting with entries queued
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b1);
            step("pre_stall");
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b1, 1'b0);
            step("stall");
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1);
            step("resume");
        end
        async_reset("async_rst");
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b1);
            step("post_rst");
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                   $urandom_range(0, 29) == 0, $urandom_range(0, 7) != 0);
            step("rand");
            if (i == 200) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
